core_fetch_prefetch: RTL

//  Instruction fetch/prefetch stage directly upstream of core_control. Issues word

---
 rtl/core_fetch_prefetch_pkg.sv | 20 ++
 rtl/core_fetch_prefetch_fifo.sv | 69 ++++++
 rtl/core_fetch_prefetch.sv | 105 ++++++++++
 3 files changed

// File: rtl/core_fetch_prefetch_pkg.sv
// Shared fetch-stage types: word/ptr, the NOP encoding, FSM states and FIFO entry layout.
package core_fetch_prefetch_pkg;

  typedef logic [29:0] ptr;
  typedef logic [31:0] word;

  localparam word NOP_INSN = 32'hE1A00000;

  typedef enum logic [1:0] {
    FETCH_IDLE,
    FETCH_REQ,
    FETCH_DISCARD
  } fetch_state;

  typedef struct packed {
    word insn;
    ptr  pc;
  } fetch_entry;

endpackage

// File: rtl/core_fetch_prefetch_fifo.sv
// DEPTH-entry FIFO of fetched {insn, pc} pairs; flush beats push and pop.
module core_fetch_fifo
  import core_fetch_prefetch_pkg::*;
#(
  parameter int unsigned DEPTH = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       push,
  input  fetch_entry push_entry,
  input  logic       pop,
  input  logic       flush,
  output fetch_entry head,
  output logic       full,
  output logic       empty
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = $clog2(DEPTH) + 1;

  fetch_entry      mem_q [DEPTH];
  logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]   count_q, count_d;
  logic            do_push, do_pop;

  assign full  = (count_q == CW'(DEPTH));
  assign empty = (count_q == '0);
  assign head  = mem_q[rd_ptr_q];

  // A pop in the same cycle frees the slot a push into a full FIFO needs.
  assign do_push = push && !flush && (!full || pop);
  assign do_pop  = pop && !flush && !empty;

  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (flush) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push)
        wr_ptr_d = (wr_ptr_q == AW'(DEPTH - 1)) ? '0 : wr_ptr_q + AW'(1);
      if (do_pop)
        rd_ptr_d = (rd_ptr_q == AW'(DEPTH - 1)) ? '0 : rd_ptr_q + AW'(1);
      count_d = count_q + CW'(do_push) - CW'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push)
      mem_q[wr_ptr_q] <= push_entry;
  end

endmodule

// File: rtl/core_fetch_prefetch.sv
// Instruction fetch/prefetch: one outstanding bus read, results buffered with their PC.
module core_fetch_prefetch
  import core_fetch_prefetch_pkg::*;
#(
  parameter int unsigned DEPTH    = 2,
  parameter ptr          RESET_PC = '0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        branch,
  input  logic [29:0] branch_target,
  output logic        fetch_start,
  output logic [29:0] fetch_addr,
  input  logic        fetch_ready,
  input  logic [31:0] fetch_data,
  output logic        insn_valid,
  output logic [31:0] insn,
  output logic [29:0] insn_pc,
  output logic        fetch_busy
);

  fetch_state state_q, state_d;
  ptr         next_pc_q, next_pc_d;
  ptr         req_addr_q, req_addr_d;
  logic       start_req;
  logic       push;
  logic       pop;
  logic       fifo_full, fifo_empty;
  fetch_entry push_entry;
  fetch_entry head;

  always_comb begin
    state_d    = state_q;
    next_pc_d  = next_pc_q;
    req_addr_d = req_addr_q;
    start_req  = 1'b0;
    push       = 1'b0;
    case (state_q)
      FETCH_IDLE: begin
        if (!branch && !fifo_full) begin
          start_req  = 1'b1;
          req_addr_d = next_pc_q;
          state_d    = FETCH_REQ;
        end
      end
      FETCH_REQ: begin
        if (fetch_ready) begin
          state_d = FETCH_IDLE;
          if (!branch) begin
            push      = 1'b1;
            next_pc_d = req_addr_q + 30'd1;
          end
        end else if (branch) begin
          state_d = FETCH_DISCARD;
        end
      end
      FETCH_DISCARD: begin
        if (fetch_ready)
          state_d = FETCH_IDLE;
      end
      default: state_d = FETCH_IDLE;
    endcase
    if (branch)
      next_pc_d = branch_target;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= FETCH_IDLE;
      next_pc_q  <= RESET_PC;
      req_addr_q <= RESET_PC;
    end else begin
      state_q    <= state_d;
      next_pc_q  <= next_pc_d;
      req_addr_q <= req_addr_d;
    end
  end

  assign push_entry = '{insn: fetch_data, pc: req_addr_q};
  assign pop        = insn_valid && !stall && !branch;

  core_fetch_fifo #(
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk        (clk),
    .rst        (rst),
    .push       (push),
    .push_entry (push_entry),
    .pop        (pop),
    .flush      (branch),
    .head       (head),
    .full       (fifo_full),
    .empty      (fifo_empty)
  );

  // In IDLE the address presented is the one about to be launched.
  assign fetch_start = start_req && !rst;
  assign fetch_addr  = (state_q == FETCH_IDLE) ? next_pc_q : req_addr_q;
  assign fetch_busy  = (state_q != FETCH_IDLE);
  assign insn_valid  = !fifo_empty;
  assign insn        = insn_valid ? head.insn : NOP_INSN;
  assign insn_pc     = insn_valid ? head.pc : '0;

endmodule
